// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared types and defaults for the FIFO read-side controller.
//   rd_state_t  : controller FSM state (IDLE, DRAIN)
//   buf_entry_t : output buffer entry {last, data} at the default word width
//   *_DEF       : default parameter values for fifo_reader
package fifo_rd_pkg;

    localparam int DATA_W_DEF    = 4;
    localparam int BURST_LEN_DEF = 8;
    localparam int TIMEOUT_DEF   = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // The skid buffer stores entries as packed {last, data} vectors of
    // width DATA_W+1, laid out exactly like this struct.
    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
// Two-entry in-order output buffer between the FIFO read port and the
// downstream valid/ready stream.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   push         : write push_data this edge (caller guarantees space)
//   push_data    : entry to store, {last, data}
//   pop          : head consumed this edge (valid and ready)
//   space        : a push this cycle will be accepted
//   valid        : buffer holds at least one entry
//   head         : oldest entry
module fifo_rd_skid #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         space,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic [1:0]   cnt;

    assign valid = (cnt != 2'd0);
    // A full buffer still has room when the head leaves in the same cycle.
    assign space = (cnt != 2'd2) || pop;
    assign head  = entry0;

    // entry0 is always the head; entry1 only holds the second word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
// Drains a 16x4 FIFO in bursts of up to BURST_LEN words and presents them
// on a valid/ready stream through a 2-entry buffer.
// Optional feature: define FIFO_RD_TIMEOUT_EN to also start a burst after
// TIMEOUT idle cycles with the FIFO non-empty.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   en              : drain enable
//   fifo_empty      : FIFO empty flag
//   fifo_threshold  : FIFO at least half full
//   fifo_rdata      : FIFO asynchronous read data
//   fifo_rd_en      : FIFO read strobe (combinational)
//   m_valid/m_ready : output handshake
//   m_data, m_last  : output word and end-of-full-burst marker
//   busy            : controller is in DRAIN
//   word_count      : words read since reset, wraps at 2^16
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       word_count
);

    generate
        if (BURST_LEN < 1 || BURST_LEN > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("fifo_reader: BURST_LEN must be 1..15 and TIMEOUT 1..255");
        end
    endgenerate

    rd_state_t         state;
    rd_state_t         next_state;
    logic [3:0]        burst_cnt;
    logic [3:0]        burst_next;
    logic              burst_done;
    logic              space;
    logic              pop;
    logic              timeout_hit;
    logic [DATA_W:0]   push_entry;
    logic [DATA_W:0]   head_entry;

    assign burst_next = burst_cnt + 4'd1;
    assign burst_done = (burst_next == 4'(BURST_LEN));
    assign pop        = m_valid && m_ready;
    assign push_entry = {burst_done, fifo_rdata};

`ifdef FIFO_RD_TIMEOUT_EN
    logic [7:0] idle_cnt;

    assign timeout_hit = (idle_cnt == 8'(TIMEOUT - 1));

    // Counts consecutive non-empty IDLE cycles; restarts whenever the FIFO
    // drains or the controller leaves IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= 8'd0;
        end else if (state != IDLE || fifo_empty || next_state == DRAIN) begin
            idle_cnt <= 8'd0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The burst ends on its last read, not one cycle later, so a waiting
    // threshold can start the next burst without an extra read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en && (fifo_threshold || timeout_hit)) next_state = DRAIN;
            end
            DRAIN: begin
                if ((fifo_rd_en && burst_done) || fifo_empty || !en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The read strobe must never fire on an empty FIFO: its pointer moves
    // on every strobe regardless of the empty flag.
    always_comb begin
        busy       = (state == DRAIN);
        fifo_rd_en = (state == DRAIN) && en && !fifo_empty && space;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt  <= 4'd0;
            word_count <= 16'd0;
        end else begin
            if (state == IDLE && next_state == DRAIN) begin
                burst_cnt <= 4'd0;
            end else if (fifo_rd_en) begin
                burst_cnt <= burst_next;
            end
            if (fifo_rd_en) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

    fifo_rd_skid #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_rd_en),
        .push_data (push_entry),
        .pop       (pop),
        .space     (space),
        .valid     (m_valid),
        .head      (head_entry)
    );

    assign m_data = head_entry[DATA_W-1:0];
    assign m_last = head_entry[DATA_W];

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
// Self-checking bench for fifo_reader. The bench owns a behavioural 16-deep
// FIFO, a scoreboard of words expected downstream (derived from the burst
// rules) and a buffer-occupancy model. Honours FIFO_RD_TIMEOUT_EN.
module tb_fifo_reader;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic        fifo_empty;
    logic        fifo_threshold;
    logic [3:0]  fifo_rdata;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] word_count;

    int vectors     = 0;
    int miscompares = 0;

    fifo_reader #(
        .DATA_W    (4),
        .BURST_LEN (8),
        .TIMEOUT   (12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_rdata     (fifo_rdata),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .word_count     (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO
    logic [3:0] fmem [16];
    logic [3:0] frp;
    logic [3:0] fwp;
    int         fcount;
    logic       wr_req;
    logic [3:0] wr_data;

    assign fifo_empty     = (fcount == 0);
    assign fifo_threshold = (fcount >= 8);
    assign fifo_rdata     = fmem[frp];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            frp    <= 4'd0;
            fwp    <= 4'd0;
            fcount <= 0;
        end else begin
            if (fifo_rd_en) frp <= frp + 4'd1;
            if (wr_req) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 4'd1;
            end
            fcount <= fcount + int'(wr_req) - int'(fifo_rd_en);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Downstream ready driver: 0 high, 1 low, 2 pattern 1,0,0,1, 3 random
    int ready_mode = 0;
    int ready_idx  = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: m_ready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ready_idx++;
        end
    end

    // Monitor: scoreboard, occupancy model and event timestamps
    logic [4:0] exp_q [$];
    int         rd_cycles [$];
    int         thr_rises [$];
    int         ne_rises [$];
    int         busy_rises [$];
    int         cyc = 0;
    int         buf_occ = 0;
    logic       stalled_prev = 1'b0;
    logic [3:0] prev_data = 4'd0;
    logic       prev_last = 1'b0;
    logic       busy_prev = 1'b0;
    logic       empty_prev = 1'b1;
    logic       thr_prev = 1'b0;
    logic       mon_push;
    logic       mon_pop;
    logic [4:0] mon_exp;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            buf_occ      = 0;
            stalled_prev = 1'b0;
            busy_prev    = 1'b0;
            empty_prev   = 1'b1;
            thr_prev     = 1'b0;
        end else begin
            mon_push = fifo_rd_en;
            mon_pop  = m_valid && m_ready;
            check_output("m_valid_vs_model", 32'(m_valid), 32'(buf_occ != 0));
            if (stalled_prev) begin
                check_output("stall_data_stable", 32'(m_data), 32'(prev_data));
                check_output("stall_last_stable", 32'(m_last), 32'(prev_last));
            end
            if (mon_push) begin
                check_output("read_while_empty", 32'(fifo_empty), 32'd0);
                if (buf_occ == 2) check_output("read_while_full", 32'(mon_pop), 32'd1);
                rd_cycles.push_back(cyc);
            end
            if (mon_pop) begin
                check_output("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check_output("m_data", 32'(m_data), 32'(mon_exp[3:0]));
                    check_output("m_last", 32'(m_last), 32'(mon_exp[4]));
                end
            end
            buf_occ      = buf_occ + int'(mon_push) - int'(mon_pop);
            stalled_prev = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last    = m_last;
            if (busy && !busy_prev)           busy_rises.push_back(cyc);
            if (!fifo_empty && empty_prev)    ne_rises.push_back(cyc);
            if (fifo_threshold && !thr_prev)  thr_rises.push_back(cyc);
            busy_prev  = busy;
            empty_prev = fifo_empty;
            thr_prev   = fifo_threshold;
        end
    end

    // Stimulus helpers
    logic [3:0] wq [$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        en     = 1'b0;
        wr_req = 1'b0;
        step(2);
        exp_q.delete();
        reset = 1'b1;
        step(1);
    endtask

    task automatic gen_words(input int n, input bit counting);
        wq.delete();
        for (int i = 0; i < n; i++) begin
            if (counting) wq.push_back(4'(i + 1));
            else          wq.push_back(4'($urandom_range(0, 15)));
        end
    endtask

    // Queue the words a burst should deliver; only a full burst marks its last word.
    task automatic expect_words(input int first, input int n, input bit full);
        logic lb;
        for (int k = 0; k < n; k++) begin
            lb = full && (k == n - 1);
            exp_q.push_back({lb, wq[first + k]});
        end
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < wq.size(); i++) begin
            wr_req  = 1'b1;
            wr_data = wq[i];
            step(1);
        end
        wr_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy || m_valid) && t < budget) begin
            step(1);
            t++;
        end
        check_output("idle_reached", 32'(t < budget), 32'd1);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int t = 0;
        while (rd_cycles.size() < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check_output("reads_reached", 32'(t < budget), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int r0;
    int t0;
    int n0;
    int b0;

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        wr_req     = 1'b0;
        wr_data    = 4'd0;
        #1 reset   = 1'b0;
        #2;
        check_output("reset_m_valid",    32'(m_valid),    32'd0);
        check_output("reset_m_last",     32'(m_last),     32'd0);
        check_output("reset_m_data",     32'(m_data),     32'd0);
        check_output("reset_busy",       32'(busy),       32'd0);
        check_output("reset_rd_en",      32'(fifo_rd_en), 32'd0);
        check_output("reset_word_count", 32'(word_count), 32'd0);

        // One threshold burst of 1..8 with ready held high
        $display("[TB] burst with ready high");
        do_reset();
        en = 1'b1;
        ready_mode = 0;
        gen_words(10, 1'b1);
        expect_words(0, 8, 1'b1);
        if (TMO) expect_words(8, 2, 1'b0);
        r0 = rd_cycles.size();
        t0 = thr_rises.size();
        apply_stimulus();
        wait_idle(200);
        check_output("a_word_count", 32'(word_count), TMO ? 32'd10 : 32'd8);
        check_output("a_fifo_left", 32'(fcount), TMO ? 32'd0 : 32'd2);
        if (rd_cycles.size() >= r0 + 8 && thr_rises.size() > t0) begin
            check_output("a_consecutive_reads", 32'(rd_cycles[r0 + 7] - rd_cycles[r0]), 32'd7);
            check_output("a_first_read_latency", 32'(rd_cycles[r0] - thr_rises[t0]), 32'd1);
        end else begin
            check_output("a_reads_seen", 32'(rd_cycles.size() - r0), 32'd8);
        end

        // Same words with ready toggling 1,0,0,1
        $display("[TB] burst with ready pattern");
        do_reset();
        en = 1'b1;
        ready_idx  = 0;
        ready_mode = 2;
        gen_words(10, 1'b1);
        expect_words(0, 8, 1'b1);
        if (TMO) expect_words(8, 2, 1'b0);
        apply_stimulus();
        wait_idle(300);
        check_output("b_word_count", 32'(word_count), TMO ? 32'd10 : 32'd8);

        // Three words: only the timeout can move them
        $display("[TB] three words below threshold");
        do_reset();
        en = 1'b1;
        ready_mode = 0;
        gen_words(3, 1'b1);
        r0 = rd_cycles.size();
        n0 = ne_rises.size();
        b0 = busy_rises.size();
        if (TMO) begin
            expect_words(0, 3, 1'b0);
            apply_stimulus();
            wait_idle(200);
            check_output("c_word_count", 32'(word_count), 32'd3);
            check_output("c_burst_started", 32'(busy_rises.size() > b0 && ne_rises.size() > n0), 32'd1);
            if (busy_rises.size() > b0 && ne_rises.size() > n0)
                check_output("c_timeout_delay", 32'(busy_rises[b0] - ne_rises[n0]), 32'd12);
        end else begin
            apply_stimulus();
            step(100);
            check_output("c_no_reads", 32'(rd_cycles.size() - r0), 32'd0);
            check_output("c_busy", 32'(busy), 32'd0);
            check_output("c_fifo_left", 32'(fcount), 32'd3);
        end

        // Drop en after the fourth read of a burst
        $display("[TB] enable dropped mid-burst");
        do_reset();
        en = 1'b0;
        ready_mode = 3;
        gen_words(10, 1'b0);
        expect_words(0, 4, 1'b0);
        apply_stimulus();
        r0 = rd_cycles.size();
        en = 1'b1;
        wait_reads(r0 + 4, 200);
        #1 en = 1'b0;
        @(negedge clk);
        check_output("d_rd_stops", 32'(fifo_rd_en), 32'd0);
        check_output("d_busy_this_cycle", 32'(busy), 32'd1);
        @(negedge clk);
        check_output("d_busy_next_cycle", 32'(busy), 32'd0);
        wait_idle(200);
        check_output("d_word_count", 32'(word_count), 32'd4);
        check_output("d_fifo_left", 32'(fcount), 32'd6);

        // Random data, two back-to-back full bursts, random ready
        for (int round = 0; round < 3; round++) begin
            $display("[TB] random round %0d", round);
            do_reset();
            en = 1'b0;
            ready_mode = 3;
            gen_words(16, 1'b0);
            expect_words(0, 8, 1'b1);
            expect_words(8, 8, 1'b1);
            apply_stimulus();
            en = 1'b1;
            wait_idle(400);
            check_output("f_word_count", 32'(word_count), 32'd16);
            check_output("f_fifo_left", 32'(fcount), 32'd0);
        end

        // Asynchronous reset with a full output buffer
        $display("[TB] reset during drain");
        do_reset();
        en = 1'b1;
        ready_mode = 1;
        gen_words(10, 1'b0);
        r0 = rd_cycles.size();
        apply_stimulus();
        wait_reads(r0 + 2, 200);
        step(3);
        @(negedge clk);
        check_output("e_valid_before", 32'(m_valid), 32'd1);
        check_output("e_busy_before", 32'(busy), 32'd1);
        check_output("e_no_read_full", 32'(fifo_rd_en), 32'd0);
        #2 reset = 1'b0;
        #1;
        check_output("e_valid_async", 32'(m_valid), 32'd0);
        check_output("e_busy_async", 32'(busy), 32'd0);
        check_output("e_count_async", 32'(word_count), 32'd0);
        check_output("e_rd_en_async", 32'(fifo_rd_en), 32'd0);
        check_output("e_data_async", 32'(m_data), 32'd0);
        en = 1'b0;
        step(2);
        exp_q.delete();
        reset = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller that drains the 16x4 FIFO and presents its words on a valid/ready stream to downstream logic. Sits on the FIFO's read port. Waits for the FIFO threshold flag, or for an optional idle timeout, then reads bursts of up to BURST_LEN words. Words pass through a 2-entry output buffer so downstream back-pressure never causes a read while the FIFO is empty, or a lost word.

## Interface
- DATA_W, 4: FIFO word width.
- BURST_LEN, 8: maximum words per burst; range 1..15.
- TIMEOUT, 12: idle cycles with FIFO non-empty before a forced burst; range 1..255. Used only with the timeout feature.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- en  in  1  drain enable.
- fifo_empty  in  1  FIFO empty flag (combinational from the FIFO pointers).
- fifo_threshold  in  1  FIFO at least half full.
- fifo_rdata  in  DATA_W  FIFO asynchronous read data; valid whenever fifo_empty=0.
- fifo_rd_en  out  1  FIFO read strobe; combinational.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_W  output word.
- m_last  out  1  marks the BURST_LEN-th word of a burst.
- busy  out  1  state is DRAIN.
- word_count  out  16  total words read since reset; wraps modulo 2^16.

## Operation
- FSM states: IDLE, DRAIN.
- IDLE to DRAIN when en=1 and either:
  - fifo_threshold=1, or
  - the timeout condition holds (timeout feature only).
- DRAIN to IDLE when any of:
  - a read completes with burst_cnt reaching BURST_LEN;
  - fifo_empty=1;
  - en=0.
- burst_cnt clears on entry to DRAIN.
- Output buffer: 2 entries, FIFO order.
  - space = (buf_cnt<2) or (m_valid and m_ready).
- fifo_rd_en = (state==DRAIN) and en and !fifo_empty and space.
  - Must never be high while fifo_empty=1, because the FIFO advances its pointer regardless of empty.
- Each read:
  - captures fifo_rdata into the buffer at that edge;
  - increments burst_cnt and word_count;
  - sets the entry's last bit when the new burst_cnt equals BURST_LEN.
- Push and pop in the same cycle: buf_cnt unchanged, order preserved.
- m_valid = (buf_cnt!=0). m_data and m_last come from the head entry.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Short burst (FIFO empties before BURST_LEN words): no m_last is generated. Return to IDLE.
- en=0 mid-burst: reads stop in that cycle; buffered words still drain downstream.

## Timing
- Reset values: state=IDLE, buf_cnt=0, burst_cnt=0, word_count=0, idle_cnt=0.
- Reset values of outputs: m_valid=0, m_last=0, m_data=0, busy=0, fifo_rd_en=0.
- fifo_threshold seen high at edge N (in IDLE, en=1): busy=1 after N, first fifo_rd_en in cycle N+1.
- Read at edge N: word on m_data with m_valid=1 in cycle N+1. This is 1-cycle latency.
- With m_ready held high: one word per cycle sustained.
- Reset assertion at any point: immediate return to reset values. Buffered words are discarded.

## Configuration
- FIFO_RD_TIMEOUT_EN defined:
  - 8-bit idle_cnt increments each IDLE cycle with fifo_empty=0.
  - idle_cnt clears on fifo_empty=1 or on leaving IDLE.
  - When idle_cnt==TIMEOUT-1 and en=1, the FSM enters DRAIN at the next edge.
- FIFO_RD_TIMEOUT_EN not defined:
  - idle_cnt is absent.
  - Only fifo_threshold starts a burst; fewer than 8 words stay in the FIFO indefinitely.

## Structure
- Shared package fifo_rd_pkg holds:
  - the state enum (IDLE, DRAIN);
  - the buffer entry type {last, data};
  - default constants BURST_LEN_DEF=8 and TIMEOUT_DEF=12.
- One sub-module: fifo_rd_skid, the 2-entry output buffer with push, pop, space and head ports.
- FSM and counters stay in fifo_reader.

## Test plan
- Write 10 words 0x1..0xA with m_ready=1.
  - One burst: 8 reads on consecutive cycles; m_data 1..8; m_last on word 8.
  - FIFO left with 2 words; return to IDLE; word_count=8.
- Same stimulus with m_ready toggling 1,0,0,1.
  - No read while buf_cnt=2 without a pop; words in order; m_data stable while stalled.
  - fifo_rd_en never high with fifo_empty=1.
- FIFO_RD_TIMEOUT_EN defined, TIMEOUT=12, write 3 words:
  - DRAIN entered exactly 12 IDLE cycles after the first non-empty cycle;
  - 3 words out, no m_last.
- FIFO_RD_TIMEOUT_EN undefined, write 3 words:
  - fifo_rd_en stays 0 for 100 cycles.
- en driven 0 after 4 reads of a burst:
  - fifo_rd_en drops in that cycle; the 4 buffered or earlier words all delivered; busy=0 next cycle.
- reset low during DRAIN with buf_cnt=2:
  - m_valid=0, busy=0, word_count=0 immediately, without waiting for a clock edge.
